// File: rtl/frag_lsu_pkg.sv
// Shared constants for the load/store unit: access-size encodings and FSM states.
package frag_lsu_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } lsu_state_e;

endpackage

// File: rtl/frag_lsu_align.sv
// Lane handling: store data replication and byte enables, load lane extraction and extension.
module frag_lsu_align
   import frag_lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_wstrb,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      st_wdata = st_data;
      st_wstrb = 4'b1111;
      case (st_funct3)
         LSU_B, LSU_BU: begin
            st_wdata = {4{st_data[7:0]}};
            st_wstrb = 4'b0001 << st_off;
         end
         LSU_H, LSU_HU: begin
            st_wdata = {2{st_data[15:0]}};
            st_wstrb = st_off[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
      ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];
      case (ld_funct3)
         LSU_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         LSU_BU:  ld_data = {24'd0, ld_byte};
         LSU_H:   ld_data = {{16{ld_half[15]}}, ld_half};
         LSU_HU:  ld_data = {16'd0, ld_half};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/frag_lsu.sv
// Load/store unit behind the execute ALU: single-outstanding req/ack data bus with writeback.
// state   | meaning
// IDLE    | no access in flight; may accept a new execute result
// BUSY    | bus request outstanding, waiting for dmem_ack
module frag_lsu
   import frag_lsu_pkg::*;
(
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        flag_JorB,
   input  logic        ex_valid,
   input  logic        lsu_ld,
   input  logic        lsu_st,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd_addr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign,
   output logic        hold
);

   lsu_state_e  state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rd_q, rd_d;
   logic        drop_q, drop_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misalign_q, misalign_d;

   logic        accept, is_mem, misaligned, issue, drop_now;
   logic [31:0] st_wdata, ld_data;
   logic [3:0]  st_wstrb;

   frag_lsu_align u_align (
      .st_funct3 (lsu_funct3),
      .st_off    (alu_result[1:0]),
      .st_data   (store_data),
      .st_wdata  (st_wdata),
      .st_wstrb  (st_wstrb),
      .ld_funct3 (funct3_q),
      .ld_off    (off_q),
      .ld_rdata  (dmem_rdata),
      .ld_data   (ld_data)
   );

   always_comb begin
      case (lsu_funct3)
         LSU_H, LSU_HU: misaligned = alu_result[0];
         LSU_B, LSU_BU: misaligned = 1'b0;
         default:       misaligned = |alu_result[1:0];
      endcase
   end

   assign is_mem   = lsu_ld | lsu_st;
   assign accept   = (state_q == ST_IDLE) & ex_valid & ~flag_JorB;
   assign issue    = accept & is_mem & ~misaligned;
   // A flush arriving in the ack cycle itself still squashes the writeback.
   assign drop_now = drop_q | flag_JorB;
   assign hold     = issue | ((state_q == ST_BUSY) & ~dmem_ack);

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wstrb_d    = wstrb_q;
      wdata_d    = wdata_q;
      off_d      = off_q;
      funct3_d   = funct3_q;
      rd_d       = rd_q;
      drop_d     = drop_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      misalign_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = alu_result;
                  wb_rd_d    = rd_addr;
               end else if (misaligned) begin
                  misalign_d = 1'b1;
               end else begin
                  state_d  = ST_BUSY;
                  req_d    = 1'b1;
                  we_d     = lsu_st;
                  addr_d   = {alu_result[31:2], 2'b00};
                  wstrb_d  = lsu_st ? st_wstrb : 4'b0000;
                  wdata_d  = st_wdata;
                  off_d    = alu_result[1:0];
                  funct3_d = lsu_funct3;
                  rd_d     = rd_addr;
                  drop_d   = 1'b0;
               end
            end
         end
         ST_BUSY: begin
            drop_d = drop_now;
            if (dmem_ack) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               drop_d  = 1'b0;
               if (!we_q && !drop_now) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = ld_data;
                  wb_rd_d    = rd_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wstrb_q    <= '0;
         wdata_q    <= '0;
         off_q      <= '0;
         funct3_q   <= '0;
         rd_q       <= '0;
         drop_q     <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wstrb_q    <= wstrb_d;
         wdata_q    <= wdata_d;
         off_q      <= off_d;
         funct3_q   <= funct3_d;
         rd_q       <= rd_d;
         drop_q     <= drop_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         misalign_q <= misalign_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wstrb = wstrb_q;
   assign dmem_wdata = wdata_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign misalign   = misalign_q;

endmodule

// File: doc/frag_lsu.md
# frag_lsu

Load/store unit placed directly downstream of the execute-stage ALU. It takes the ALU result as the effective address and drives a single-outstanding req/ack data-memory bus. Load data is lane-extracted and sign- or zero-extended; non-memory results are forwarded unchanged. A hold is raised toward the pipeline while a memory access is in flight, using the same hold contract as the ALU (hold falls in the completion cycle).

## Interface
Parameters: none. The 32-bit datapath and 5-bit register index are fixed.

Ports:
- sys_clk  in  1  sole clock; all state updates on rising edge
- sys_rst  in  1  synchronous, active-high reset
- flag_JorB  in  1  jump/branch flush; squashes the current instruction's writeback
- ex_valid  in  1  execute-stage result valid this cycle
- lsu_ld  in  1  instruction is a load
- lsu_st  in  1  instruction is a store (lsu_ld & lsu_st never both 1)
- lsu_funct3  in  3  size: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- alu_result  in  32  effective address, or the result for non-memory ops
- store_data  in  32  rs2 value for stores
- rd_addr  in  5  destination register
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address: {alu_result[31:2], 2'b00}
- dmem_wstrb  out  4  byte enables (writes only; 0 on reads)
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  one-cycle completion strobe; valid only while dmem_req=1
- dmem_rdata  in  32  read data, valid in the ack cycle
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- misalign  out  1  one-cycle misaligned-access pulse
- hold  out  1  stall request to upstream stages

## Operation
- States: IDLE and BUSY. Reset forces IDLE; all registered outputs reset to 0.
- Accept: state=IDLE & ex_valid & ~flag_JorB.
- Non-memory op accepted: next cycle wb_valid=1, wb_data=alu_result, wb_rd=rd_addr. No hold.
- Alignment: H/HU/SH are misaligned when addr[0]=1. W/SW are misaligned when addr[1:0]≠0. A misaligned access issues no bus request. Next cycle: misalign=1 and wb_valid=0. No hold.
- Aligned memory op accepted: next cycle state=BUSY and dmem_req=1. dmem_we, dmem_addr, dmem_wstrb, dmem_wdata and rd/funct3/addr[1:0] are registered and stay stable until ack.
- Store lanes:
  - SB: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=0011 or 1100.
  - SW: wstrb=1111.
- Load extraction: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]. B/H sign-extend; BU/HU zero-extend.
- BUSY & dmem_ack:
  - dmem_req drops next cycle; state returns to IDLE.
  - Load: next cycle wb_valid=1 with the extracted data.
  - Store: wb_valid stays 0.
- Flush:
  - flag_JorB in IDLE blocks acceptance.
  - flag_JorB while BUSY sets a drop flag. The bus transaction still completes (stores are still written), but wb_valid is suppressed.
  - The drop flag clears on return to IDLE.
- wb_rd=0 is still reported; the register file ignores it.

## Timing
- hold = (IDLE & accept & aligned memory op) | (BUSY & ~dmem_ack). It is combinational and falls in the ack cycle, so upstream advances on the ack edge and the next instruction is seen in IDLE with no duplicate accept.
- Latency from accept edge T with ack at cycle T+1+k (k≥0): dmem_req high T+1 .. T+1+k, wb_valid at T+2+k.
- Back-to-back: a new op can be accepted in the cycle wb_valid is high. Maximum throughput is one memory op per 2+k cycles.
- sys_rst asserted mid-BUSY: state=IDLE and dmem_req=0 next cycle. A late dmem_ack while IDLE is ignored.
- wb_valid and misalign are never asserted together.

## Structure
- Shared package frag_lsu_pkg holds:
  - funct3 size constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - state encoding (ST_IDLE, ST_BUSY)
- One combinational sub-module, frag_lsu_align: store lane replication plus wstrb generation, and load extraction plus extension. The FSM and registers stay in frag_lsu.

## Test plan
- ADD result 0x0000_1234, rd=5, ex_valid=1 -> next cycle wb_valid=1, wb_data=0x0000_1234, wb_rd=5; hold never 1.
- LB addr 0x103, ack after 2 wait cycles, rdata=0x80AA_BBCC -> dmem_addr=0x100, wstrb=0, hold high 3 cycles, wb_data=0xFFFF_FF80.
- LHU addr 0x102, rdata=0x8001_0000 with immediate ack -> wb_data=0x0000_8001. Same access as LH -> wb_data=0xFFFF_8001.
- SB addr 0x21, data 0x0000_00A5 -> dmem_we=1, wstrb=0010, wdata=0xA5A5_A5A5, no wb_valid. SW addr 0x22 -> misalign pulse, no dmem_req.
- LW issued, then flag_JorB=1 during BUSY, ack 3 cycles later -> dmem_req held until ack, wb_valid stays 0, next op accepted normally.
- sys_rst=1 while BUSY -> dmem_req=0, hold=0 next cycle; a subsequent stray dmem_ack produces no wb_valid.
